// File: rtl/clk_gate_ctrl.sv
// Enable controller for a clock gate cell: wakes the gated domain on request and gates it off after an idle timeout.
// Optional macro CLK_GATE_FORCE_EN adds a TEST_MODE input that forces CLK_EN high for scan/DFT.
module clk_gate_ctrl #(
  parameter int unsigned WAKE_CYCLES  = 2,
  parameter int unsigned IDLE_TIMEOUT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ,
  input  logic       BUSY,
`ifdef CLK_GATE_FORCE_EN
  input  logic       TEST_MODE,
`endif
  output logic       CLK_EN,
  output logic       READY,
  output logic [1:0] CG_STATE
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_WAKE = 2'b01,
    ST_ON   = 2'b10,
    ST_IDLE = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             clk_en_q, clk_en_d;
  logic             ready_q, ready_d;

  // Saturating increment of the shared wake/idle counter.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state logic; outputs are decoded from the next state so they register with it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OFF: begin
        if (REQ) begin
          state_d = ST_WAKE;
          cnt_d   = '0;
        end
      end
      ST_WAKE: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_ON: begin
        if (!REQ && !BUSY) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        if (REQ || BUSY) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
    clk_en_d = (state_d != ST_OFF);
    ready_d  = (state_d == ST_ON) || (state_d == ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      clk_en_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
      ready_q  <= ready_d;
    end
  end

`ifdef CLK_GATE_FORCE_EN
  assign CLK_EN = clk_en_q | TEST_MODE;
`else
  assign CLK_EN = clk_en_q;
`endif
  assign READY    = ready_q;
  assign CG_STATE = state_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed literal sequences plus randomized REQ/BUSY/reset against a cycle-count model.
module tb_clk_gate_ctrl;

  localparam int unsigned WAKE = 2;
  localparam int unsigned IDLE = 8;

  logic       CLK;
  logic       RST;
  logic       REQ;
  logic       BUSY;
  logic       TEST_MODE;
  logic       CLK_EN;
  logic       READY;
  logic [1:0] CG_STATE;

  int total = 0;
  int bad   = 0;

  clk_gate_ctrl #(.WAKE_CYCLES(WAKE), .IDLE_TIMEOUT(IDLE), .CNT_W(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ      (REQ),
    .BUSY     (BUSY),
`ifdef CLK_GATE_FORCE_EN
    .TEST_MODE(TEST_MODE),
`endif
    .CLK_EN   (CLK_EN),
    .READY    (READY),
    .CG_STATE (CG_STATE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Model: clock enabled flag, wake cycles still to serve, length of the current idle run once ready.
  bit m_en;
  int m_wake_left;
  int m_idle_run;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_en        <= 1'b0;
      m_wake_left <= 0;
      m_idle_run  <= 0;
    end else if (!m_en) begin
      if (REQ) begin
        m_en        <= 1'b1;
        m_wake_left <= WAKE;
        m_idle_run  <= 0;
      end
    end else if (m_wake_left > 0) begin
      m_wake_left <= m_wake_left - 1;
    end else if (REQ || BUSY) begin
      m_idle_run <= 0;
    end else if (m_idle_run + 1 > int'(IDLE)) begin
      m_en       <= 1'b0;
      m_idle_run <= 0;
    end else begin
      m_idle_run <= m_idle_run + 1;
    end
  end

  function automatic logic [1:0] exp_state();
    if (!m_en) return 2'b00;
    if (m_wake_left > 0) return 2'b01;
    if (m_idle_run == 0) return 2'b10;
    return 2'b11;
  endfunction

  function automatic logic exp_clk_en();
    return m_en | (TEST_MODE === 1'b1);
  endfunction

  function automatic logic exp_ready();
    return m_en && (m_wake_left == 0);
  endfunction

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    chk("model_state", CG_STATE, exp_state());
    chk("model_clk_en", {1'b0, CLK_EN}, {1'b0, exp_clk_en()});
    chk("model_ready", {1'b0, READY}, {1'b0, exp_ready()});
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk_lit(input string name, input logic [1:0] st);
    chk({name, "_state"}, CG_STATE, st);
    chk({name, "_clk_en"}, {1'b0, CLK_EN}, {1'b0, st != 2'b00});
    chk({name, "_ready"}, {1'b0, READY}, {1'b0, st[1]});
  endtask

  logic [1:0] pulse_seq [12];
  int         req_div;
  int         busy_div;

  initial begin
    pulse_seq = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11,
                  2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    RST = 1'b0; REQ = 1'b0; BUSY = 1'b0; TEST_MODE = 1'b0;
    tick();
    tick();
    chk_lit("reset", 2'b00);
    RST = 1'b1;
    tick();
    chk_lit("idle_off", 2'b00);

    // Short REQ pulse: 2 WAKE, 1 ON, 8 IDLE_WAIT, then OFF with CLK_EN/READY dropping together.
    REQ = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_lit($sformatf("pulse%0d", i), pulse_seq[i]);
      REQ = 1'b0;
    end

    // Idle abort at count 7 by BUSY.
    REQ = 1'b1;
    tick(); tick(); tick();
    chk_lit("abort_on", 2'b10);
    REQ = 1'b0;
    tick();
    chk_lit("abort_iw0", 2'b11);
    for (int i = 0; i < 7; i++) tick();
    chk_lit("abort_iw7", 2'b11);
    BUSY = 1'b1;
    tick();
    chk_lit("abort_back_on", 2'b10);
    BUSY = 1'b0;

    // Drain to OFF, then reset in the middle of WAKE.
    for (int i = 0; i < 10; i++) tick();
    chk_lit("drained", 2'b00);
    REQ = 1'b1;
    tick();
    chk_lit("rst_wake", 2'b01);
    RST = 1'b0;
    #1;
    chk_lit("rst_async", 2'b00);
    tick();
    RST = 1'b1;
    tick();
    chk_lit("rewake0", 2'b01);
    tick();
    chk_lit("rewake1", 2'b01);
    tick();
    chk_lit("rewake_on", 2'b10);
    REQ = 1'b0;
    for (int i = 0; i < 10; i++) tick();

`ifdef CLK_GATE_FORCE_EN
    TEST_MODE = 1'b1;
    #1;
    chk("force_clk_en", {1'b0, CLK_EN}, 2'b01);
    chk("force_ready", {1'b0, READY}, 2'b00);
    chk("force_state", CG_STATE, 2'b00);
    tick();
    TEST_MODE = 1'b0;
`endif

    // Randomized segments with varying request/busy density and occasional async reset pulses.
    for (int seg = 0; seg < 30; seg++) begin
      case ($urandom_range(0, 2))
        0:       req_div = 2;
        1:       req_div = 12;
        default: req_div = 40;
      endcase
      busy_div = ($urandom_range(0, 1) == 0) ? 6 : 50;
      for (int c = 0; c < 100; c++) begin
        tick();
        REQ  = ($urandom_range(0, req_div - 1) == 0);
        BUSY = ($urandom_range(0, busy_div - 1) == 0);
`ifdef CLK_GATE_FORCE_EN
        TEST_MODE = ($urandom_range(0, 19) == 0);
`endif
        if ($urandom_range(0, 149) == 0) begin
          RST = 1'b0;
          #1;
          chk("rand_rst_state", CG_STATE, 2'b00);
          chk("rand_rst_ready", {1'b0, READY}, 2'b00);
          RST = 1'b1;
        end
      end
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
